uart_rx_ctrl: RTL

Control and buffering front-end for uart_receiver. Holds host-written receiver configuration in shadow registers and commits it only while the receiver is idle, restarting the receiver cleanly on each commit. Tags each received word with the error/noise pulses of its frame and buffers it in a FWFT FIFO. Keeps sticky status, including overrun, for the host.

---
 rtl/uart_rx_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Control and buffering front-end for a UART receiver.
//   * Host configuration is captured into shadow registers on cfg_wr and only
//     committed to the receiver while it is idle.
//   * Every commit passes through a single APPLY cycle with rx_en low, so the
//     receiver restarts cleanly.
//   * Each received word is tagged with the noise/error pulses seen during
//     its frame and buffered in a first-word-fall-through FIFO.
//   * Sticky status bits (noise, parity, stop, overrun, drain timeout) are
//     kept for the host and cleared with a write-1-to-clear mask.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   host_en             : global receive enable
//   cfg_wr, cfg_*       : pending configuration write strobe and values
//   cfg_busy            : a written configuration has not been committed yet
//   rx_en               : enable to the receiver
//   baud_rate .. ign_stop : committed configuration to the receiver
//   rx_vld_p, rx_byte, rx_parity : received word strobe and contents
//   *_noise_p, parity_err_p, stop_err_p : per-frame quality pulses
//   rx_state            : receiver state, zero when idle
//   rd_en, rd_data, rd_vld, fifo_cnt, fifo_flush : receive FIFO host side
//                         rd_data = {stop_err, parity_err, noise, rx_parity, rx_byte}
//   sts, sts_clr        : sticky status {tmo, ovr, stop_err, parity_err, noise}
//                         and its write-1-to-clear mask
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DRAIN_TMO  = 4096,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_en,
    input  logic             cfg_wr,
    input  logic [15:0]      cfg_baud_rate,
    input  logic             cfg_word_len,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_type,
    input  logic [1:0]       cfg_stop_len,
    input  logic             cfg_samp_mode,
    input  logic             cfg_irda_mode,
    input  logic             cfg_ign_stop,
    output logic             cfg_busy,
    output logic             rx_en,
    output logic [15:0]      baud_rate,
    output logic             word_len,
    output logic             parity_en,
    output logic             parity_type,
    output logic [1:0]       stop_len,
    output logic             samp_mode,
    output logic             irda_mode,
    output logic             ign_stop,
    input  logic             rx_vld_p,
    input  logic [7:0]       rx_byte,
    input  logic             rx_parity,
    input  logic             start_noise_p,
    input  logic             data_noise_p,
    input  logic             parity_noise_p,
    input  logic             stop_noise_p,
    input  logic             parity_err_p,
    input  logic             stop_err_p,
    input  logic [7:0]       rx_state,
    input  logic             rd_en,
    output logic [11:0]      rd_data,
    output logic             rd_vld,
    output logic [CNT_W-1:0] fifo_cnt,
    input  logic             fifo_flush,
    output logic [4:0]       sts,
    input  logic [4:0]       sts_clr
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DCNT_W = $clog2(DRAIN_TMO) + 1;

    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_TMO - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_APPLY = 2'd3
    } state_t;

    // Pack a received word and its frame quality flags into one FIFO entry.
    function automatic logic [11:0] make_entry(
        input logic       serr,
        input logic       perr,
        input logic       noise,
        input logic       par,
        input logic [7:0] data
    );
        make_entry = {serr, perr, noise, par, data};
    endfunction

    state_t state_r, state_s;
    logic   tmo_set_s;
    logic   rx_en_r;

    logic [DCNT_W-1:0] drain_cnt_r;

    logic        pend_r;
    logic [15:0] pend_baud_r;
    logic        pend_word_len_r, pend_parity_en_r, pend_parity_type_r;
    logic [1:0]  pend_stop_len_r;
    logic        pend_samp_mode_r, pend_irda_mode_r, pend_ign_stop_r;

    logic [15:0] baud_rate_r;
    logic        word_len_r, parity_en_r, parity_type_r;
    logic [1:0]  stop_len_r;
    logic        samp_mode_r, irda_mode_r, ign_stop_r;

    logic        noise_f_r, perr_f_r, serr_f_r;
    logic        any_noise_s;
    logic [11:0] entry_s;

    logic [11:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             full_s, pop_s, wr_s, ovr_s;
    logic [4:0]       sts_r, sts_set_s;

    // Next-state decode for the configuration commit sequencer.
    always_comb begin
        state_s   = state_r;
        tmo_set_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (cfg_wr) begin
                    state_s = ST_APPLY;
                end else if (host_en && !pend_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_RUN: begin
                if (cfg_wr) begin
                    state_s = ST_DRAIN;
                end else if (!host_en) begin
                    state_s = ST_OFF;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Receiver idle or host disable commits at once; otherwise
                // give up waiting after DRAIN_TMO cycles and flag it.
                if (rx_state == 8'd0) begin
                    state_s = ST_APPLY;
                end else if (!host_en) begin
                    state_s = ST_APPLY;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_s   = ST_APPLY;
                    tmo_set_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_APPLY: begin
                // A write landing in APPLY becomes a fresh pending config.
                if (cfg_wr) begin
                    state_s = host_en ? ST_DRAIN : ST_APPLY;
                end else begin
                    state_s = host_en ? ST_RUN : ST_OFF;
                end
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase
    end

    // State register and registered receiver enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
            rx_en_r <= 1'b0;
        end else begin
            state_r <= state_s;
            rx_en_r <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
        end
    end

    // Drain wait counter: zero outside DRAIN, counts cycles spent in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_r <= '0;
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DCNT_ONE;
        end else begin
            drain_cnt_r <= '0;
        end
    end

    // Shadow configuration: latched on cfg_wr, pending flag cleared by APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r             <= 1'b0;
            pend_baud_r        <= 16'd16;
            pend_word_len_r    <= 1'b0;
            pend_parity_en_r   <= 1'b0;
            pend_parity_type_r <= 1'b0;
            pend_stop_len_r    <= 2'd0;
            pend_samp_mode_r   <= 1'b0;
            pend_irda_mode_r   <= 1'b0;
            pend_ign_stop_r    <= 1'b0;
        end else if (cfg_wr) begin
            pend_r             <= 1'b1;
            pend_baud_r        <= cfg_baud_rate;
            pend_word_len_r    <= cfg_word_len;
            pend_parity_en_r   <= cfg_parity_en;
            pend_parity_type_r <= cfg_parity_type;
            pend_stop_len_r    <= cfg_stop_len;
            pend_samp_mode_r   <= cfg_samp_mode;
            pend_irda_mode_r   <= cfg_irda_mode;
            pend_ign_stop_r    <= cfg_ign_stop;
        end else if (state_r == ST_APPLY) begin
            pend_r <= 1'b0;
        end
    end

    // Committed configuration: updated on every edge that ends an APPLY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_rate_r   <= 16'd16;
            word_len_r    <= 1'b0;
            parity_en_r   <= 1'b0;
            parity_type_r <= 1'b0;
            stop_len_r    <= 2'd0;
            samp_mode_r   <= 1'b0;
            irda_mode_r   <= 1'b0;
            ign_stop_r    <= 1'b0;
        end else if (state_r == ST_APPLY) begin
            baud_rate_r   <= pend_baud_r;
            word_len_r    <= pend_word_len_r;
            parity_en_r   <= pend_parity_en_r;
            parity_type_r <= pend_parity_type_r;
            stop_len_r    <= pend_stop_len_r;
            samp_mode_r   <= pend_samp_mode_r;
            irda_mode_r   <= pend_irda_mode_r;
            ign_stop_r    <= pend_ign_stop_r;
        end
    end

    // Frame tag: accumulated flags plus any pulse arriving with rx_vld_p.
    assign any_noise_s = start_noise_p | data_noise_p | parity_noise_p | stop_noise_p;
    assign entry_s     = make_entry(serr_f_r | stop_err_p,
                                    perr_f_r | parity_err_p,
                                    noise_f_r | any_noise_s,
                                    rx_parity, rx_byte);

    // Per-frame flag accumulators; cleared on each word and on a restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            noise_f_r <= 1'b0;
            perr_f_r  <= 1'b0;
            serr_f_r  <= 1'b0;
        end else if (rx_vld_p || (state_r == ST_APPLY)) begin
            noise_f_r <= 1'b0;
            perr_f_r  <= 1'b0;
            serr_f_r  <= 1'b0;
        end else begin
            noise_f_r <= noise_f_r | any_noise_s;
            perr_f_r  <= perr_f_r | parity_err_p;
            serr_f_r  <= serr_f_r | stop_err_p;
        end
    end

    // FIFO handshake: flush wins over everything; a pop frees room for a
    // push arriving while full, so that case is not an overrun.
    assign full_s = (cnt_r == CNT_FULL);
    assign pop_s  = rd_en && (cnt_r != '0) && !fifo_flush;
    assign wr_s   = rx_vld_p && !fifo_flush && (!full_s || pop_s);
    assign ovr_s  = rx_vld_p && !fifo_flush && full_s && !pop_s;

    // FIFO storage write port (contents need no reset; rd_vld guards them).
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || fifo_flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Sticky status: a set in the same cycle as its clear keeps the bit at 1.
    assign sts_set_s = {tmo_set_s, ovr_s, wr_s & entry_s[11],
                        wr_s & entry_s[10], wr_s & entry_s[9]};

    // Sticky status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sts_r <= 5'd0;
        end else begin
            sts_r <= (sts_r & ~sts_clr) | sts_set_s;
        end
    end

    assign cfg_busy    = pend_r;
    assign rx_en       = rx_en_r;
    assign baud_rate   = baud_rate_r;
    assign word_len    = word_len_r;
    assign parity_en   = parity_en_r;
    assign parity_type = parity_type_r;
    assign stop_len    = stop_len_r;
    assign samp_mode   = samp_mode_r;
    assign irda_mode   = irda_mode_r;
    assign ign_stop    = ign_stop_r;
    assign rd_data     = mem_r[rd_ptr_r];
    assign rd_vld      = (cnt_r != '0);
    assign fifo_cnt    = cnt_r;
    assign sts         = sts_r;

endmodule
